// File: rtl/icache_pkg.sv
// icache_pkg: state encoding, tag entry type and geometry helpers shared by icache_2way_ctrl and its way arrays
package icache_pkg;
  localparam int TAG_MAX_W = 32;
  typedef enum logic [2:0] {IDLE, LOOKUP, MISS_REQ, FILL, RESPOND} cache_state_e;
  typedef struct packed {
    logic                 valid;
    logic [TAG_MAX_W-1:0] tag;
  } tag_entry_t;
  function automatic int idx_w(input int sets);
    return $clog2(sets);
  endfunction
  function automatic int woff_w(input int words_per_blk);
    return $clog2(words_per_blk);
  endfunction
  function automatic int byte_w(input int data_w);
    return $clog2(data_w / 8);
  endfunction
  function automatic int off_w(input int data_w, input int words_per_blk);
    return $clog2(words_per_blk * data_w / 8);
  endfunction
endpackage

// File: rtl/icache_way_array.sv
// icache_way_array: one cache way (valid bits, tags, block data); synchronous write, combinational read
module icache_way_array
  import icache_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int SETS = 64,
  parameter int WORDS_PER_BLK = 8,
  parameter int TAG_W = 6,
  localparam int IW = idx_w(SETS),
  localparam int WW = woff_w(WORDS_PER_BLK)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr_all_i,
  input  logic [IW-1:0]     idx_i,
  input  logic [WW-1:0]     rd_word_i,
  output tag_entry_t        ent_o,
  output logic [DATA_W-1:0] rd_data_o,
  input  logic              inval_i,
  input  logic              wr_en_i,
  input  logic [WW-1:0]     wr_word_i,
  input  logic [DATA_W-1:0] wr_data_i,
  input  logic              tag_wr_i,
  input  logic [TAG_W-1:0]  tag_i
);
  logic [SETS-1:0]   valid_q;
  logic [TAG_W-1:0]  tag_q [SETS];
  logic [DATA_W-1:0] data_q [SETS*WORDS_PER_BLK];
  always_ff @(posedge clk) begin
    if (rst || clr_all_i) valid_q <= '0;
    else if (tag_wr_i) valid_q[idx_i] <= 1'b1;
    else if (inval_i) valid_q[idx_i] <= 1'b0;
  end
  always_ff @(posedge clk) begin
    if (tag_wr_i) tag_q[idx_i] <= tag_i;
    if (wr_en_i) data_q[{idx_i, wr_word_i}] <= wr_data_i;
  end
  assign ent_o     = '{valid: valid_q[idx_i], tag: TAG_MAX_W'(tag_q[idx_i])};
  assign rd_data_o = data_q[{idx_i, rd_word_i}];
endmodule

// File: rtl/icache_2way_ctrl.sv
// icache_2way_ctrl: 2-way set-associative I-cache with LRU replacement, block fill and flush.
// Define ICACHE_STATS_EN to add saturating hit_cnt/miss_cnt outputs.
module icache_2way_ctrl
  import icache_pkg::*;
#(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16,
  parameter int SETS = 64,
  parameter int WORDS_PER_BLK = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  input  logic [ADDR_W-1:0] req_addr,
  output logic              req_ready,
  output logic              resp_valid,
  output logic [DATA_W-1:0] resp_data,
  input  logic              flush,
  output logic              mem_rd_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_data,
`ifdef ICACHE_STATS_EN
  output logic [15:0]       hit_cnt,
  output logic [15:0]       miss_cnt,
`endif
  input  logic              mem_data_valid
);
  localparam int OFF_W = off_w(DATA_W, WORDS_PER_BLK);
  localparam int IDX_W = idx_w(SETS);
  localparam int TAG_W = ADDR_W - IDX_W - OFF_W;
  localparam int BYTE_W = byte_w(DATA_W);
  localparam int WW = woff_w(WORDS_PER_BLK);
  localparam logic [WW-1:0] LAST = WW'(WORDS_PER_BLK - 1);

  cache_state_e      state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [WW-1:0]     cnt_q, cnt_d;
  logic              victim_q, victim_d, flush_pend_q, flush_pend_d;
  logic [SETS-1:0]   lru_q, lru_d;
  logic [TAG_W-1:0]  tag;
  logic [IDX_W-1:0]  idx;
  logic [WW-1:0]     word;
  tag_entry_t        ent [2];
  logic [DATA_W-1:0] rd_data [2];
  logic              hit0, hit1, hit, clr_all, inval, fill_wr, tag_wr, rd_way, unused_lsb;

  assign {tag, idx}  = addr_q[ADDR_W-1:OFF_W];
  assign word        = addr_q[OFF_W-1:BYTE_W];
  assign unused_lsb  = ^addr_q;
  assign hit0        = ent[0].valid && ent[0].tag == TAG_MAX_W'(tag);
  assign hit1        = ent[1].valid && ent[1].tag == TAG_MAX_W'(tag);
  assign hit         = hit0 || hit1;
  assign mem_addr    = {addr_q[ADDR_W-1:OFF_W], OFF_W'(0)};
  // way 0 wins a double hit; RESPOND always reads the way just filled
  assign rd_way      = (state_q == RESPOND) ? victim_q : !hit0;
  assign resp_data   = resp_valid ? rd_data[rd_way] : '0;

  for (genvar w = 0; w < 2; w++) begin : g_way
    icache_way_array #(
      .DATA_W(DATA_W), .SETS(SETS), .WORDS_PER_BLK(WORDS_PER_BLK), .TAG_W(TAG_W)
    ) u_way (
      .clk      (clk),
      .rst      (rst),
      .clr_all_i(clr_all),
      .idx_i    (idx),
      .rd_word_i(word),
      .ent_o    (ent[w]),
      .rd_data_o(rd_data[w]),
      .inval_i  (inval && victim_d == 1'(w)),
      .wr_en_i  (fill_wr && victim_q == 1'(w)),
      .wr_word_i(cnt_q),
      .wr_data_i(mem_data),
      .tag_wr_i (tag_wr && victim_q == 1'(w)),
      .tag_i    (tag)
    );
  end

  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    cnt_d        = cnt_q;
    victim_d     = victim_q;
    flush_pend_d = flush_pend_q || flush;
    lru_d        = lru_q;
    clr_all      = 1'b0;
    inval        = 1'b0;
    fill_wr      = 1'b0;
    tag_wr       = 1'b0;
    req_ready    = 1'b0;
    resp_valid   = 1'b0;
    mem_rd_req   = 1'b0;
    case (state_q)
      IDLE: begin
        req_ready = !rst && !flush && !flush_pend_q;
        if (flush || flush_pend_q) begin
          clr_all      = 1'b1;
          lru_d        = '0;
          flush_pend_d = 1'b0;
        end else if (req_valid && req_ready) begin
          addr_d  = req_addr;
          state_d = LOOKUP;
        end
      end
      LOOKUP: begin
        resp_valid = hit;
        if (hit) lru_d[idx] = hit0;
        state_d = hit ? IDLE : MISS_REQ;
      end
      MISS_REQ: begin
        mem_rd_req = 1'b1;
        victim_d   = !ent[0].valid ? 1'b0 : !ent[1].valid ? 1'b1 : lru_q[idx];
        inval      = 1'b1;
        cnt_d      = '0;
        state_d    = FILL;
      end
      FILL: begin
        fill_wr = mem_data_valid;
        if (mem_data_valid) begin
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == LAST) begin
            tag_wr     = 1'b1;
            lru_d[idx] = !victim_q;
            state_d    = RESPOND;
          end
        end
      end
      RESPOND: begin
        resp_valid = 1'b1;
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      addr_q       <= '0;
      cnt_q        <= '0;
      victim_q     <= 1'b0;
      flush_pend_q <= 1'b0;
      lru_q        <= '0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      cnt_q        <= cnt_d;
      victim_q     <= victim_d;
      flush_pend_q <= flush_pend_d;
      lru_q        <= lru_d;
    end
  end

`ifdef ICACHE_STATS_EN
  logic [15:0] hit_cnt_q, miss_cnt_q;
  always_ff @(posedge clk) begin
    if (rst) begin
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else if (state_q == LOOKUP) begin
      if (hit && hit_cnt_q != 16'hFFFF) hit_cnt_q <= hit_cnt_q + 16'd1;
      if (!hit && miss_cnt_q != 16'hFFFF) miss_cnt_q <= miss_cnt_q + 16'd1;
    end
  end
  assign hit_cnt  = hit_cnt_q;
  assign miss_cnt = miss_cnt_q;
`endif
endmodule

// File: tb/tb_icache_2way_ctrl.sv
// tb_icache_2way_ctrl: directed table, corner sequences and random traffic against a set/way model
module tb_icache_2way_ctrl;
  logic        clk, rst, req_valid, req_ready, resp_valid, flush, mem_rd_req, mem_data_valid;
  logic [15:0] req_addr, resp_data, mem_addr, mem_data;
`ifdef ICACHE_STATS_EN
  logic [15:0] hit_cnt, miss_cnt;
`endif
  int n_vec = 0, n_err = 0, m_hits = 0, m_misses = 0;
  bit          mv [64][2];
  logic [5:0]  mt [64][2];
  int          ml [64];

  typedef struct {
    logic [15:0] addr;
    bit          hit;
    logic [15:0] data;
  } vec_t;
  vec_t tbl [8];

  icache_2way_ctrl dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_addr(req_addr), .req_ready(req_ready),
    .resp_valid(resp_valid), .resp_data(resp_data), .flush(flush), .mem_rd_req(mem_rd_req),
    .mem_addr(mem_addr), .mem_data(mem_data),
`ifdef ICACHE_STATS_EN
    .hit_cnt(hit_cnt), .miss_cnt(miss_cnt),
`endif
    .mem_data_valid(mem_data_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation still running, required to finish");
    $fatal(1, "timeout");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Backing memory: word i of block b
  function automatic logic [15:0] memw(input logic [15:0] b, input int i);
    return (b ^ 16'hA040) + 16'(i);
  endfunction

  function automatic int find_way(input logic [15:0] a);
    for (int w = 0; w < 2; w++)
      if (mv[a[9:4]][w] && mt[a[9:4]][w] == a[15:10]) return w;
    return -1;
  endfunction

  task automatic model_flush();
    for (int s = 0; s < 64; s++) begin
      mv[s][0] = 0;
      mv[s][1] = 0;
      ml[s] = 0;
    end
  endtask

  task automatic model_update(input logic [15:0] a);
    int s, w, v;
    s = int'(a[9:4]);
    w = find_way(a);
    if (w >= 0) ml[s] = 1 - w;
    else begin
      v = !mv[s][0] ? 0 : !mv[s][1] ? 1 : ml[s];
      mv[s][v] = 1;
      mt[s][v] = a[15:10];
      ml[s] = 1 - v;
    end
  endtask

  // One request from IDLE back to IDLE; fl_word pulses flush with that fill word
  task automatic access(input logic [15:0] a, input bit eh, input logic [15:0] ed, input int fl_word = -1);
    logic [15:0] blk;
    blk = a & 16'hFFF0;
    req_addr = a;
    req_valid = 1;
    #1;
    chk("req_ready_idle", req_ready, 1);
    step();
    req_valid = 0;
    #1;
    chk("resp_valid_lookup", resp_valid, eh);
    chk("mem_rd_req_lookup", mem_rd_req, 0);
    if (eh) begin
      chk("hit_data", resp_data, ed);
      m_hits++;
    end else begin
      m_misses++;
      step();
      chk("mem_rd_req", mem_rd_req, 1);
      chk("mem_addr", mem_addr, blk);
      chk("resp_valid_missreq", resp_valid, 0);
      step();
      chk("mem_rd_req_once", mem_rd_req, 0);
      for (int i = 0; i < 8; i++) begin
        mem_data_valid = 0;
        flush = 0;
        repeat ($urandom_range(0, 2)) step();
        mem_data_valid = 1;
        mem_data = memw(blk, i);
        flush = (i == fl_word);
        step();
      end
      mem_data_valid = 0;
      flush = 0;
      #1;
      chk("resp_valid_fill", resp_valid, 1);
      chk("fill_data", resp_data, ed);
      chk("req_ready_respond", req_ready, 0);
    end
    step();
    model_update(a);
  endtask

  initial begin
    logic [15:0] a;
    int w;
    tbl[0] = '{16'h0046, 0, 16'hA003};
    tbl[1] = '{16'h004E, 1, 16'hA007};
    tbl[2] = '{16'h1040, 0, 16'hB000};
    tbl[3] = '{16'h0040, 1, 16'hA000};
    tbl[4] = '{16'h2040, 0, 16'h8000};
    tbl[5] = '{16'h0040, 1, 16'hA000};
    tbl[6] = '{16'h1040, 0, 16'hB000};
    tbl[7] = '{16'h2046, 0, 16'h8003};
    rst = 1;
    req_valid = 0;
    req_addr = 0;
    flush = 0;
    mem_data = 0;
    mem_data_valid = 0;
    model_flush();
    step();
    step();
    chk("rst_req_ready", req_ready, 0);
    chk("rst_resp_valid", resp_valid, 0);
    chk("rst_mem_rd_req", mem_rd_req, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_resp_data", resp_data, 0);
    rst = 0;
    #1;
    chk("req_ready_after_rst", req_ready, 1);
`ifdef ICACHE_STATS_EN
    chk("hit_cnt_rst", hit_cnt, 0);
    chk("miss_cnt_rst", miss_cnt, 0);
`endif
    for (int i = 0; i < 8; i++) access(tbl[i].addr, tbl[i].hit, tbl[i].data);

    // flush together with a request in IDLE
    req_addr = 16'h2046;
    req_valid = 1;
    flush = 1;
    #1;
    chk("req_ready_flush_req", req_ready, 0);
    step();
    req_valid = 0;
    flush = 0;
    #1;
    chk("not_accepted", resp_valid, 0);
    chk("req_ready_post_flush", req_ready, 1);
    model_flush();
    access(16'h2046, 0, 16'h8003);

    // flush during a fill: response delivered, flush applied on the next IDLE cycle
    access(16'h0046, 1'(find_way(16'h0046) >= 0), 16'hA003, 4);
    chk("req_ready_pending_flush", req_ready, 0);
    step();
    model_flush();
    chk("req_ready_flush_done", req_ready, 1);
    access(16'h0046, 0, 16'hA003);

    // reset in the middle of a fill, then stray memory words
    req_addr = 16'h3052;
    req_valid = 1;
    step();
    req_valid = 0;
    step();
    step();
    for (int i = 0; i < 3; i++) begin
      mem_data_valid = 1;
      mem_data = memw(16'h3050, i);
      step();
    end
    mem_data_valid = 0;
    rst = 1;
    step();
    chk("midfill_rst_req_ready", req_ready, 0);
    chk("midfill_rst_resp_valid", resp_valid, 0);
    rst = 0;
    #1;
    chk("midfill_req_ready", req_ready, 1);
    for (int i = 0; i < 5; i++) begin
      mem_data_valid = 1;
      mem_data = 16'hDEAD;
      step();
      chk("stray_resp_valid", resp_valid, 0);
      chk("stray_mem_rd_req", mem_rd_req, 0);
    end
    mem_data_valid = 0;
    model_flush();
    m_hits = 0;
    m_misses = 0;
`ifdef ICACHE_STATS_EN
    chk("hit_cnt_midfill_rst", hit_cnt, 0);
    chk("miss_cnt_midfill_rst", miss_cnt, 0);
`endif
    access(16'h3052, 0, memw(16'h3050, 1));

    // random traffic over a few conflicting sets
    for (int k = 0; k < 200; k++) begin
      if ($urandom_range(0, 19) == 0) begin
        flush = 1;
        #1;
        chk("req_ready_rand_flush", req_ready, 0);
        step();
        flush = 0;
        model_flush();
      end
      a = {6'($urandom_range(0, 3)), 6'($urandom_range(0, 2) * 21), 4'($urandom)};
      w = find_way(a);
      access(a, w >= 0, memw(a & 16'hFFF0, int'(a[3:1])));
    end
`ifdef ICACHE_STATS_EN
    chk("hit_cnt_final", hit_cnt, 32'(m_hits));
    chk("miss_cnt_final", miss_cnt, 32'(m_misses));
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
